// File: rtl/seq_alu_if.sv
// ----------------------------------------------------------------------------
// seq_alu_if: operand/result handshake bundle for seq_alu.
//   master : drives InValid, OpCode, OperandA, OperandB, OutReady;
//            observes InReady, OutValid, Result, FlagZ/N/C/V/Err.
//   slave  : the ALU side, directions mirrored.
// Parameter WIDTH must match the seq_alu instance it connects to.
// ----------------------------------------------------------------------------
interface seq_alu_if #(
    parameter int unsigned WIDTH = 16
);
    logic             InValid;
    logic             InReady;
    logic [3:0]       OpCode;
    logic [WIDTH-1:0] OperandA;
    logic [WIDTH-1:0] OperandB;
    logic             OutValid;
    logic             OutReady;
    logic [WIDTH-1:0] Result;
    logic             FlagZ;
    logic             FlagN;
    logic             FlagC;
    logic             FlagV;
    logic             FlagErr;

    modport master (
        output InValid, OpCode, OperandA, OperandB, OutReady,
        input  InReady, OutValid, Result, FlagZ, FlagN, FlagC, FlagV, FlagErr
    );

    modport slave (
        input  InValid, OpCode, OperandA, OperandB, OutReady,
        output InReady, OutValid, Result, FlagZ, FlagN, FlagC, FlagV, FlagErr
    );
endinterface

// File: rtl/seq_alu.sv
// ----------------------------------------------------------------------------
// seq_alu: registered ALU with valid/ready handshake and iterative shift/mul.
//   Clock   : rising-edge system clock
//   Reset_n : asynchronous active-low reset
//   bus     : seq_alu_if.slave (operands/opcode in, result/flags out)
// Single-cycle ops deliver OutValid one cycle after acceptance; SHL/SHR take
// one cycle per shift position, MUL takes WIDTH cycles of shift-add.
// Optional feature macro: SEQ_ALU_MUL_EN (enables opcode 11 MUL; when
// undefined opcode 11 is reported as illegal and no multiplier exists).
// ----------------------------------------------------------------------------
module seq_alu #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input logic      Clock,
    input logic      Reset_n,
    seq_alu_if.slave bus
);
    localparam int unsigned CW = SHW + 1;
    localparam int unsigned HW = WIDTH / 2;
`ifdef SEQ_ALU_MUL_EN
    localparam int unsigned PW = 2 * WIDTH;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
`ifdef SEQ_ALU_MUL_EN
        , S_MUL = 2'd3
`endif
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_acc, w_acc_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic             r_shl, w_shl_nxt;
    logic             r_in_ready, r_out_valid;
    logic [WIDTH-1:0] r_result, w_result_nxt;
    logic             r_z, r_n, r_c, r_v, r_err;
    logic             w_z_nxt, w_n_nxt, w_c_nxt, w_v_nxt, w_err_nxt;

    // Final-result capture request and its payload
    logic             w_fin;
    logic [WIDTH-1:0] w_fin_res;
    logic             w_fin_c, w_fin_v, w_fin_err;

    logic [WIDTH:0]   w_sum, w_diff;
    logic [WIDTH-1:0] w_step;
    logic             w_step_out;

`ifdef SEQ_ALU_MUL_EN
    logic [PW-1:0]    r_prod, w_prod_nxt;
    logic [PW-1:0]    r_mcand, w_mcand_nxt;
    logic [WIDTH-1:0] r_mplier, w_mplier_nxt;
`endif

    // Extra MSB of the sum is the carry; of the difference, the borrow
    assign w_sum  = {1'b0, bus.OperandA} + {1'b0, bus.OperandB};
    assign w_diff = {1'b0, bus.OperandA} - {1'b0, bus.OperandB};

    // One shift step of the working value and the bit it pushes out
    assign w_step     = r_shl ? {r_acc[WIDTH-2:0], 1'b0} : {1'b0, r_acc[WIDTH-1:1]};
    assign w_step_out = r_shl ? r_acc[WIDTH-1] : r_acc[0];

    // Next-state and datapath update
    always_comb begin
        w_state_nxt  = r_state;
        w_acc_nxt    = r_acc;
        w_cnt_nxt    = r_cnt;
        w_shl_nxt    = r_shl;
        w_result_nxt = r_result;
        w_z_nxt      = r_z;
        w_n_nxt      = r_n;
        w_c_nxt      = r_c;
        w_v_nxt      = r_v;
        w_err_nxt    = r_err;
        w_fin        = 1'b0;
        w_fin_res    = '0;
        w_fin_c      = 1'b0;
        w_fin_v      = 1'b0;
        w_fin_err    = 1'b0;
`ifdef SEQ_ALU_MUL_EN
        w_prod_nxt   = r_prod;
        w_mcand_nxt  = r_mcand;
        w_mplier_nxt = r_mplier;
`endif

        case (r_state)
            S_IDLE: begin
                if (bus.InValid) begin
                    case (bus.OpCode)
                        4'd0: begin w_fin = 1'b1; w_fin_res = bus.OperandA & bus.OperandB; end
                        4'd1: begin w_fin = 1'b1; w_fin_res = bus.OperandA | bus.OperandB; end
                        4'd2: begin w_fin = 1'b1; w_fin_res = bus.OperandA ^ bus.OperandB; end
                        4'd3: begin w_fin = 1'b1; w_fin_res = ~bus.OperandA; end
                        4'd4: begin
                            w_fin     = 1'b1;
                            w_fin_res = w_sum[WIDTH-1:0];
                            w_fin_c   = w_sum[WIDTH];
                            w_fin_v   = (bus.OperandA[WIDTH-1] == bus.OperandB[WIDTH-1]) &&
                                        (w_sum[WIDTH-1] != bus.OperandA[WIDTH-1]);
                        end
                        4'd5: begin
                            w_fin     = 1'b1;
                            w_fin_res = w_diff[WIDTH-1:0];
                            w_fin_c   = w_diff[WIDTH];
                            w_fin_v   = (bus.OperandA[WIDTH-1] != bus.OperandB[WIDTH-1]) &&
                                        (w_diff[WIDTH-1] != bus.OperandA[WIDTH-1]);
                        end
                        4'd6: begin
                            w_fin     = 1'b1;
                            w_fin_res = WIDTH'(bus.OperandA == bus.OperandB);
                        end
                        4'd7: begin
                            w_fin     = 1'b1;
                            w_fin_res = {bus.OperandA[HW-1:0], bus.OperandB[HW-1:0]};
                        end
                        4'd8: begin
                            w_fin     = 1'b1;
                            w_fin_res = {bus.OperandB[WIDTH-1:HW], bus.OperandA[HW-1:0]};
                        end
                        4'd9, 4'd10: begin
                            // Zero shift amount completes like a single-cycle op
                            if (bus.OperandB[SHW-1:0] == '0) begin
                                w_fin     = 1'b1;
                                w_fin_res = bus.OperandA;
                            end else begin
                                w_state_nxt = S_SHIFT;
                                w_acc_nxt   = bus.OperandA;
                                w_cnt_nxt   = CW'(bus.OperandB[SHW-1:0]);
                                w_shl_nxt   = (bus.OpCode == 4'd9);
                            end
                        end
`ifdef SEQ_ALU_MUL_EN
                        4'd11: begin
                            w_state_nxt  = S_MUL;
                            w_prod_nxt   = '0;
                            w_mcand_nxt  = PW'(bus.OperandA);
                            w_mplier_nxt = bus.OperandB;
                            w_cnt_nxt    = CW'(WIDTH);
                        end
`endif
                        default: begin w_fin = 1'b1; w_fin_err = 1'b1; end
                    endcase
                end
            end
            S_SHIFT: begin
                w_acc_nxt = w_step;
                w_cnt_nxt = r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    w_fin     = 1'b1;
                    w_fin_res = w_step;
                    w_fin_c   = w_step_out;
                end
            end
`ifdef SEQ_ALU_MUL_EN
            S_MUL: begin
                // Shift-add: add the shifted multiplicand for each set multiplier bit
                w_prod_nxt   = r_prod + (r_mplier[0] ? r_mcand : '0);
                w_mcand_nxt  = {r_mcand[PW-2:0], 1'b0};
                w_mplier_nxt = {1'b0, r_mplier[WIDTH-1:1]};
                w_cnt_nxt    = r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    w_fin     = 1'b1;
                    w_fin_res = w_prod_nxt[WIDTH-1:0];
                    w_fin_c   = |w_prod_nxt[PW-1:WIDTH];
                end
            end
`endif
            S_DONE: begin
                if (bus.OutReady) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Result and flags are captured together; an illegal op reports only Err
        if (w_fin) begin
            w_state_nxt  = S_DONE;
            w_result_nxt = w_fin_res;
            w_z_nxt      = !w_fin_err && (w_fin_res == '0);
            w_n_nxt      = !w_fin_err && w_fin_res[WIDTH-1];
            w_c_nxt      = w_fin_c;
            w_v_nxt      = w_fin_v;
            w_err_nxt    = w_fin_err;
        end
    end

    // State and datapath registers; handshake outputs follow the next state
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_shl       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_z         <= 1'b0;
            r_n         <= 1'b0;
            r_c         <= 1'b0;
            r_v         <= 1'b0;
            r_err       <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            r_prod      <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_cnt       <= w_cnt_nxt;
            r_shl       <= w_shl_nxt;
            r_in_ready  <= (w_state_nxt == S_IDLE);
            r_out_valid <= (w_state_nxt == S_DONE);
            r_result    <= w_result_nxt;
            r_z         <= w_z_nxt;
            r_n         <= w_n_nxt;
            r_c         <= w_c_nxt;
            r_v         <= w_v_nxt;
            r_err       <= w_err_nxt;
`ifdef SEQ_ALU_MUL_EN
            r_prod      <= w_prod_nxt;
            r_mcand     <= w_mcand_nxt;
            r_mplier    <= w_mplier_nxt;
`endif
        end
    end

    assign bus.InReady  = r_in_ready;
    assign bus.OutValid = r_out_valid;
    assign bus.Result   = r_result;
    assign bus.FlagZ    = r_z;
    assign bus.FlagN    = r_n;
    assign bus.FlagC    = r_c;
    assign bus.FlagV    = r_v;
    assign bus.FlagErr  = r_err;
endmodule

// File: tb/tb_seq_alu.sv
// ----------------------------------------------------------------------------
// tb_seq_alu: self-checking bench for seq_alu (WIDTH=16). Directed cases
// followed by random operations, each compared against an arithmetic
// reference model for result, flags {Z,N,C,V,Err} and latency.
// Follows SEQ_ALU_MUL_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_seq_alu;
    localparam int unsigned W = 16;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    seq_alu_if #(.WIDTH(W)) bus ();

    seq_alu #(.WIDTH(W)) dut (
        .Clock   (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: result, flags {Z,N,C,V,Err}, cycles from accept to OutValid
    task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic [4:0] f, output int lat);
        int          s;
        int          sa;
        int          sb;
        logic        c;
        logic        v;
        logic        e;
        logic [31:0] wide;
        s    = int'(b[3:0]);
        sa   = int'($signed(a));
        sb   = int'($signed(b));
        c    = 1'b0;
        v    = 1'b0;
        e    = 1'b0;
        lat  = 1;
        r    = '0;
        wide = '0;
        case (op)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: r = a ^ b;
            4'd3: r = ~a;
            4'd4: begin
                wide = 32'(a) + 32'(b);
                r    = wide[15:0];
                c    = wide[16];
                v    = (sa + sb > 32767) || (sa + sb < -32768);
            end
            4'd5: begin
                r = a - b;
                c = (a < b);
                v = (sa - sb > 32767) || (sa - sb < -32768);
            end
            4'd6: r = (a == b) ? 16'd1 : 16'd0;
            4'd7: r = {a[7:0], b[7:0]};
            4'd8: r = {b[15:8], a[7:0]};
            4'd9: begin
                r   = a << s;
                c   = (s == 0) ? 1'b0 : a[16-s];
                lat = 1 + s;
            end
            4'd10: begin
                r   = a >> s;
                c   = (s == 0) ? 1'b0 : a[s-1];
                lat = 1 + s;
            end
`ifdef SEQ_ALU_MUL_EN
            4'd11: begin
                wide = 32'(a) * 32'(b);
                r    = wide[15:0];
                c    = (wide[31:16] != 16'd0);
                lat  = 17;
            end
`endif
            default: e = 1'b1;
        endcase
        if (e) begin
            r = '0;
            f = 5'b00001;
        end else begin
            f = {(r == 16'd0), r[15], c, v, 1'b0};
        end
    endtask

    function automatic logic [4:0] dut_flags();
        return {bus.FlagZ, bus.FlagN, bus.FlagC, bus.FlagV, bus.FlagErr};
    endfunction

    // Entered and left at a negative clock edge
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int hold);
        logic [W-1:0] er;
        logic [4:0]   ef;
        int           el;
        int           lat;
        model(op, a, b, er, ef, el);
        check("in_ready_idle", 32'(bus.InReady), 32'd1);
        bus.InValid  = 1'b1;
        bus.OpCode   = op;
        bus.OperandA = a;
        bus.OperandB = b;
        bus.OutReady = 1'b0;
        @(posedge clk);
        #1;
        // Scramble inputs after accept; the unit must use latched operands
        bus.InValid  = 1'b0;
        bus.OpCode   = 4'($urandom);
        bus.OperandA = 16'($urandom);
        bus.OperandB = 16'($urandom);
        lat = 1;
        @(negedge clk);
        while (!bus.OutValid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check($sformatf("latency op%0d", op), 32'(lat), 32'(el));
        check($sformatf("result op%0d a=%h b=%h", op, a, b), 32'(bus.Result), 32'(er));
        check($sformatf("flags op%0d a=%h b=%h", op, a, b), 32'(dut_flags()), 32'(ef));
        for (int h = 0; h < hold; h++) begin
            bus.InValid = 1'b1;
            bus.OpCode  = 4'($urandom);
            @(negedge clk);
            check("hold_out_valid", 32'(bus.OutValid), 32'd1);
            check("hold_result", 32'(bus.Result), 32'(er));
            check("hold_flags", 32'(dut_flags()), 32'(ef));
            check("hold_in_ready", 32'(bus.InReady), 32'd0);
        end
        bus.InValid  = 1'b0;
        bus.OutReady = 1'b1;
        @(negedge clk);
        bus.OutReady = 1'b0;
        check("release_out_valid", 32'(bus.OutValid), 32'd0);
        check("release_in_ready", 32'(bus.InReady), 32'd1);
    endtask

    initial begin
        logic [3:0] iter_op;
        logic [W-1:0] iter_b;
        n_checks     = 0;
        n_errors     = 0;
        rst_n        = 1'b0;
        bus.InValid  = 1'b0;
        bus.OpCode   = 4'd0;
        bus.OperandA = '0;
        bus.OperandB = '0;
        bus.OutReady = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_in_ready", 32'(bus.InReady), 32'd1);
        check("reset_out_valid", 32'(bus.OutValid), 32'd0);
        check("reset_result", 32'(bus.Result), 32'd0);
        check("reset_flags", 32'(dut_flags()), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        run_op(4'd4, 16'h7FFF, 16'h0001, 0);
        run_op(4'd5, 16'h0003, 16'h0005, 0);
        run_op(4'd7, 16'h12AB, 16'h34CD, 0);
        run_op(4'd8, 16'h12AB, 16'h34CD, 0);
        run_op(4'd9, 16'h8001, 16'h0003, 0);
        run_op(4'd10, 16'h0005, 16'h0001, 0);
        run_op(4'd9, 16'hBEEF, 16'h0000, 0);
        run_op(4'd10, 16'h8000, 16'h000F, 0);
        run_op(4'd11, 16'h0100, 16'h0100, 0);
        run_op(4'd11, 16'hFFFF, 16'hFFFF, 0);
        run_op(4'd6, 16'h5A5A, 16'h5A5A, 0);
        run_op(4'd4, 16'hFFFF, 16'h0001, 5);
        run_op(4'd5, 16'h8000, 16'h0001, 0);
        run_op(4'd15, 16'h1234, 16'h5678, 0);

        // Reset in the middle of an iterative operation
`ifdef SEQ_ALU_MUL_EN
        iter_op = 4'd11;
        iter_b  = 16'h0100;
`else
        iter_op = 4'd9;
        iter_b  = 16'h000F;
`endif
        bus.InValid  = 1'b1;
        bus.OpCode   = iter_op;
        bus.OperandA = 16'h0100;
        bus.OperandB = iter_b;
        @(posedge clk);
        #1;
        bus.InValid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus.OutValid), 32'd0);
        check("midrst_flags", 32'(dut_flags()), 32'd0);
        check("midrst_result", 32'(bus.Result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_out_valid", 32'(bus.OutValid), 32'd0);
        run_op(4'hF, 16'hAAAA, 16'h5555, 0);

        // Random operations
        for (int i = 0; i < 80; i++) begin
            run_op(4'($urandom), 16'($urandom), 16'($urandom), int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the 16-bit combinational ALU.
- Adds a valid/ready operand handshake, a registered result and flag set, and multi-cycle iterative shift and multiply.
- Sits between the register-file read stage and the writeback mux of the CPU datapath.
- Single-cycle ops return one cycle after acceptance; iterative ops hold the unit busy until complete.

Parameters:
- WIDTH, 16, operand/result width in bits; must be even and >= 4.
- SHW, $clog2(WIDTH), width of the shift-amount field taken from OperandB[SHW-1:0].

Ports:
- Clock  input  1  single system clock, rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- InValid  input  1  operands/opcode valid.
- InReady  output  1  unit can accept a new operation.
- OpCode  input  4  operation select.
- OperandA  input  WIDTH  first operand.
- OperandB  input  WIDTH  second operand / shift amount.
- OutValid  output  1  Result and flags valid.
- OutReady  input  1  consumer takes the result.
- Result  output  WIDTH  registered result.
- FlagZ, FlagN, FlagC, FlagV  output  1 each  zero, negative, carry/borrow, signed overflow.
- FlagErr  output  1  illegal opcode.

Behaviour:
- Reset (Reset_n low, asynchronous): state IDLE, InReady=1, OutValid=0, Result=0, all flags=0.
- Reset mid-operation aborts the operation with no output.
- Handshake:
  - Accept on Clock edge when InValid && InReady.
  - Operands are latched at accept; input changes afterwards are ignored.
  - InReady=1 only in IDLE.
  - OutValid holds with Result and flags stable until OutValid && OutReady, then the next state is IDLE.
  - Back-to-back single-cycle ops: accept at N, OutValid at N+1, accept again at N+2.
- States: IDLE -> (single-cycle op) DONE; IDLE -> SHIFT; IDLE -> MUL; SHIFT/MUL -> DONE on count exhaustion; DONE -> IDLE on OutReady.
- Opcodes, single-cycle (OutValid at N+1):
  - 0 AND; 1 OR; 2 XOR; 3 NOT A.
  - 4 ADD: A+B.
  - 5 SUB: A-B.
  - 6 EQ: Result = {0..., A==B}.
  - 7 SETH: Result = {A[WIDTH/2-1:0], B[WIDTH/2-1:0]}.
  - 8 SETL: Result = {B[WIDTH-1:WIDTH/2], A[WIDTH/2-1:0]}.
- Opcodes, iterative:
  - 9 SHL: logical left, one bit per cycle, shamt = B[SHW-1:0].
  - 10 SHR: logical right, one bit per cycle, same shamt.
  - OutValid at N+1+shamt; shamt=0 behaves as a single-cycle op.
  - 11 MUL: shift-add, low WIDTH bits of the unsigned product, exactly WIDTH iteration cycles; OutValid at N+WIDTH+1.
- Opcodes 12-15: illegal. Result=0, FlagErr=1, other flags 0, OutValid at N+1.
- Flags are computed from the final result and registered together with it. FlagErr=0 for all legal opcodes.
  - Z = (Result==0); N = Result[WIDTH-1], for every legal opcode.
  - ADD: C = carry out of bit WIDTH-1.
  - SUB: C = borrow (1 when A<B unsigned).
  - ADD/SUB: V = signed overflow; V=0 for all other opcodes.
  - SHL/SHR: C = last bit shifted out; C=0 when shamt=0.
  - MUL: C = 1 if any upper product bit is nonzero.
  - Logic, EQ, SETH, SETL: C=0.
- Arithmetic wraps modulo 2^WIDTH. No input is undefined for any legal opcode.

Optional Feature:
- SEQ_ALU_MUL_EN defined: opcode 11 performs MUL as specified; the multiplier/product registers are present.
- SEQ_ALU_MUL_EN undefined: opcode 11 is illegal (Result=0, FlagErr=1, OutValid at N+1); no MUL state or logic.

Test Plan:
- ADD A=0x7FFF B=0x0001 accepted at cycle N -> OutValid at N+1, Result=0x8000, N=1 V=1 C=0 Z=0.
- SUB A=0x0003 B=0x0005 -> Result=0xFFFE, C=1, N=1, V=0; then SETH A=0x12AB B=0x34CD -> 0xABCD.
- SHL A=0x8001 B=3 -> OutValid at N+4, Result=0x0008, C=0.
  SHR A=0x0005 B=1 -> Result=0x0002, C=1.
  SHL with B=0 -> OutValid at N+1, Result=A.
- MUL (macro defined) A=0x0100 B=0x0100 -> OutValid at N+17, Result=0x0000, Z=1, C=1.
  Same stimulus with the macro undefined -> N+1, FlagErr=1.
- Hold OutReady=0 for 5 cycles after a result -> Result/flags stable, InReady=0, InValid ignored; release -> InReady=1 next cycle.
- Assert Reset_n low mid-MUL (cycle N+5) -> OutValid=0, flags=0 immediately; after release InReady=1. Opcode 0xF -> Result=0, FlagErr=1.
